// File: rtl/store_buffer.sv
// store_buffer: in-order FIFO store buffer between the memory stage and dbus.
// Stores drain through an addr_ok/data_ok handshake; loads see byte-granular
// forwarding, merged youngest-first across all valid entries.
// Optional build macro STORE_BUFFER_COALESCE_EN merges a store into the
// youngest entry when the word addresses match.
module store_buffer #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     st_valid,
   input  logic [ADDR_W-1:0]        st_addr,
   input  logic [DATA_W-1:0]        st_data,
   input  logic [DATA_W/8-1:0]      st_strobe,
   output logic                     st_ready,
   input  logic [ADDR_W-1:0]        ld_addr,
   output logic [DATA_W/8-1:0]      ld_fwd_mask,
   output logic [DATA_W-1:0]        ld_fwd_data,
   output logic                     ld_fwd_full,
   output logic                     dreq_valid,
   output logic [ADDR_W-1:0]        dreq_addr,
   output logic [DATA_W-1:0]        dreq_data,
   output logic [DATA_W/8-1:0]      dreq_strobe,
   input  logic                     dresp_addr_ok,
   input  logic                     dresp_data_ok,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned NB = DATA_W / 8;
   localparam int          PW = $clog2(DEPTH);
   localparam int          CW = PW + 1;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

   state_e              state_q;
   logic                dreq_valid_q;
   logic [ADDR_W-1:0]   addr_q [DEPTH];
   logic [DATA_W-1:0]   data_q [DEPTH];
   logic [NB-1:0]       strb_q [DEPTH];
   logic [DEPTH-1:0]    valid_q;
   logic [PW-1:0]       head_q, tail_q;
   logic [CW-1:0]       count_q, count_d;

   logic                full;
   logic                pop;
   logic                alloc;
   logic [NB-1:0]       fwd_mask;
   logic [DATA_W-1:0]   fwd_data;
   logic                unused_addr_lsbs;

   assign full = (count_q == CW'(DEPTH));
   assign pop  = ((state_q == S_REQ) && dresp_addr_ok && dresp_data_ok) ||
                 ((state_q == S_WAIT) && dresp_data_ok);

`ifdef STORE_BUFFER_COALESCE_EN
   logic [PW-1:0] young_idx;
   logic          merge_ok;
   logic          do_merge;

   assign young_idx = tail_q - PW'(1);
   // The head is frozen once it is on the bus, so it may only absorb a store while idle.
   assign merge_ok  = (count_q != '0) && valid_q[young_idx] &&
                      (addr_q[young_idx][ADDR_W-1:2] == st_addr[ADDR_W-1:2]) &&
                      !((young_idx == head_q) && (state_q != S_IDLE));
   assign st_ready  = !full || merge_ok;
   assign do_merge  = st_valid && merge_ok;
   assign alloc     = st_valid && !merge_ok && !full;
`else
   assign st_ready  = !full;
   assign alloc     = st_valid && !full;
`endif

   assign unused_addr_lsbs = ^{ld_addr[1:0], st_addr[1:0]};

   // Next entry count: allocation and pop in the same cycle cancel out.
   always_comb begin
      count_d = count_q;
      if (alloc && !pop)
         count_d = count_q + CW'(1);
      else if (!alloc && pop)
         count_d = count_q - CW'(1);
   end

   // Pointer, valid-bit and count bookkeeping.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         valid_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (alloc) begin
            valid_q[tail_q] <= 1'b1;
            tail_q          <= tail_q + PW'(1);
         end
         if (pop) begin
            valid_q[head_q] <= 1'b0;
            head_q          <= head_q + PW'(1);
         end
         count_q <= count_d;
      end
   end

   // Entry payload storage; not reset, qualified by valid_q.
   always_ff @(posedge clk) begin
      if (alloc) begin
         addr_q[tail_q] <= st_addr;
         data_q[tail_q] <= st_data;
         strb_q[tail_q] <= st_strobe;
      end
`ifdef STORE_BUFFER_COALESCE_EN
      if (do_merge) begin
         for (int unsigned b = 0; b < NB; b++) begin
            if (st_strobe[b])
               data_q[young_idx][8*b +: 8] <= st_data[8*b +: 8];
         end
         strb_q[young_idx] <= strb_q[young_idx] | st_strobe;
      end
`endif
   end

   // Drain FSM: present head, wait for address then data acceptance, then pop.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= S_IDLE;
         dreq_valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (count_q != '0) begin
                  state_q      <= S_REQ;
                  dreq_valid_q <= 1'b1;
               end
            end
            S_REQ: begin
               if (dresp_addr_ok) begin
                  dreq_valid_q <= 1'b0;
                  state_q      <= dresp_data_ok ? S_IDLE : S_WAIT;
               end
            end
            S_WAIT: begin
               if (dresp_data_ok)
                  state_q <= S_IDLE;
            end
            default: begin
               state_q      <= S_IDLE;
               dreq_valid_q <= 1'b0;
            end
         endcase
      end
   end

   // Forwarding: walk oldest to youngest so younger matching lanes overwrite older ones.
   always_comb begin
      logic [PW-1:0] idx;
      idx      = '0;
      fwd_mask = '0;
      fwd_data = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         idx = head_q + PW'(k);
         if (valid_q[idx] && (addr_q[idx][ADDR_W-1:2] == ld_addr[ADDR_W-1:2])) begin
            for (int unsigned b = 0; b < NB; b++) begin
               if (strb_q[idx][b]) begin
                  fwd_mask[b]          = 1'b1;
                  fwd_data[8*b +: 8]   = data_q[idx][8*b +: 8];
               end
            end
         end
      end
   end

   assign ld_fwd_mask = fwd_mask;
   assign ld_fwd_data = fwd_data;
   assign ld_fwd_full = &fwd_mask;

   assign dreq_valid  = dreq_valid_q;
   assign dreq_addr   = addr_q[head_q];
   assign dreq_data   = data_q[head_q];
   assign dreq_strobe = strb_q[head_q];

   assign empty = (count_q == '0) && (state_q == S_IDLE);
   assign count = count_q;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: drain transactions are checked against a
// scoreboard queue filled at enqueue time; other outputs against constants.
module tb_store_buffer;

   localparam int DEPTH = 4;
   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int NB    = DW / 8;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          st_valid = 1'b0;
   logic [AW-1:0] st_addr = '0;
   logic [DW-1:0] st_data = '0;
   logic [NB-1:0] st_strobe = '0;
   logic          st_ready;
   logic [AW-1:0] ld_addr = '0;
   logic [NB-1:0] ld_fwd_mask;
   logic [DW-1:0] ld_fwd_data;
   logic          ld_fwd_full;
   logic          dreq_valid;
   logic [AW-1:0] dreq_addr;
   logic [DW-1:0] dreq_data;
   logic [NB-1:0] dreq_strobe;
   logic          dresp_addr_ok = 1'b0;
   logic          dresp_data_ok = 1'b0;
   logic          empty;
   logic [$clog2(DEPTH):0] count;

   store_buffer #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .resetn(resetn),
      .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
      .st_strobe(st_strobe), .st_ready(st_ready),
      .ld_addr(ld_addr), .ld_fwd_mask(ld_fwd_mask), .ld_fwd_data(ld_fwd_data),
      .ld_fwd_full(ld_fwd_full),
      .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_data(dreq_data),
      .dreq_strobe(dreq_strobe),
      .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
      .empty(empty), .count(count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [NB-1:0] s;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Move to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one store (caller is just after a rising edge); it is accepted on the next edge.
   task automatic enq(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] s);
      exp_t e;
      st_valid  = 1'b1;
      st_addr   = a;
      st_data   = d;
      st_strobe = s;
      @(negedge clk);
      check("enq_st_ready", 64'(st_ready), 64'd1);
      if (st_ready) begin
         e.a = a; e.d = d; e.s = s;
         exp_q.push_back(e);
      end
      step();
      st_valid = 1'b0;
   endtask

   // Asynchronous reset asserted between edges; outputs must clear with no clock.
   task automatic async_reset(input string tag);
      #2;
      resetn = 1'b0;
      #1;
      check({tag, "_count"}, 64'(count), 64'd0);
      check({tag, "_dreq_valid"}, 64'(dreq_valid), 64'd0);
      check({tag, "_empty"}, 64'(empty), 64'd1);
      check({tag, "_st_ready"}, 64'(st_ready), 64'd1);
      check({tag, "_fwd_mask"}, 64'(ld_fwd_mask), 64'd0);
      check({tag, "_fwd_full"}, 64'(ld_fwd_full), 64'd0);
      exp_q.delete();
      step();
      resetn = 1'b1;
   endtask

   // Scoreboard: every address handshake retires the oldest expected store.
   always @(negedge clk) begin
      if (resetn && dreq_valid && dresp_addr_ok) begin
         if (exp_q.size() == 0) begin
            check("drain_unexpected", 64'(exp_q.size()), 64'd1);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("drain_addr", 64'(dreq_addr), 64'(e.a));
            check("drain_data", 64'(dreq_data), 64'(e.d));
            check("drain_strobe", 64'(dreq_strobe), 64'(e.s));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_st_ready", 64'(st_ready), 64'd1);
      check("rst_dreq_valid", 64'(dreq_valid), 64'd0);
      check("rst_empty", 64'(empty), 64'd1);
      check("rst_count", 64'(count), 64'd0);
      check("rst_fwd_mask", 64'(ld_fwd_mask), 64'd0);
      check("rst_fwd_data", 64'(ld_fwd_data), 64'd0);
      check("rst_fwd_full", 64'(ld_fwd_full), 64'd0);
      resetn = 1'b1;
      step();

      // Single store drained with the bus always ready
      dresp_addr_ok = 1'b1;
      dresp_data_ok = 1'b1;
      enq(32'h100, 32'hAABBCCDD, 4'hF);
      @(negedge clk);
      check("t1_cyc1_dreq_valid", 64'(dreq_valid), 64'd0);
      check("t1_cyc1_count", 64'(count), 64'd1);
      step();
      @(negedge clk);
      check("t1_cyc2_dreq_valid", 64'(dreq_valid), 64'd1);
      check("t1_cyc2_dreq_addr", 64'(dreq_addr), 64'h100);
      step();
      @(negedge clk);
      check("t1_empty", 64'(empty), 64'd1);
      check("t1_count", 64'(count), 64'd0);
      check("t1_dreq_valid", 64'(dreq_valid), 64'd0);
      check("t1_sb_drained", 64'(exp_q.size()), 64'd0);
      step();

      // Fill to full with the bus stalled, then slow data completion
      dresp_addr_ok = 1'b0;
      dresp_data_ok = 1'b0;
      enq(32'h400, 32'h11111111, 4'hF);
      enq(32'h404, 32'h22222222, 4'hF);
      enq(32'h408, 32'h33333333, 4'hF);
      enq(32'h40C, 32'h44444444, 4'hF);
      st_valid  = 1'b1;
      st_addr   = 32'h410;
      st_data   = 32'h55555555;
      st_strobe = 4'hF;
      @(negedge clk);
      check("t2_full_count", 64'(count), 64'd4);
      check("t2_full_st_ready", 64'(st_ready), 64'd0);
      step();
      @(negedge clk);
      check("t2_held_st_ready", 64'(st_ready), 64'd0);
      check("t2_req_dreq_valid", 64'(dreq_valid), 64'd1);
      step();
      dresp_addr_ok = 1'b1;
      step();
      dresp_addr_ok = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t2_wait_dreq_valid", 64'(dreq_valid), 64'd0);
         check("t2_wait_count", 64'(count), 64'd4);
         step();
      end
      dresp_data_ok = 1'b1;
      dresp_addr_ok = 1'b1;
      @(negedge clk);
      check("t2_pop_cycle_st_ready", 64'(st_ready), 64'd0);
      check("t2_pop_cycle_count", 64'(count), 64'd4);
      step();
      @(negedge clk);
      check("t2_after_pop_count", 64'(count), 64'd3);
      check("t2_after_pop_st_ready", 64'(st_ready), 64'd1);
      if (st_ready) begin
         exp_t e;
         e.a = 32'h410; e.d = 32'h55555555; e.s = 4'hF;
         exp_q.push_back(e);
      end
      step();
      st_valid = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (empty) break;
      end
      check("t2_drain_empty", 64'(empty), 64'd1);
      check("t2_sb_drained", 64'(exp_q.size()), 64'd0);
      dresp_addr_ok = 1'b0;
      dresp_data_ok = 1'b0;
      step();

      // Forwarding: youngest-first lane merge, miss, partial hit
      enq(32'h200, 32'h11223344, 4'hF);
      enq(32'h202, 32'h55660000, 4'hC);
      ld_addr = 32'h200;
      @(negedge clk);
      check("t3_fwd_mask", 64'(ld_fwd_mask), 64'hF);
      check("t3_fwd_data", 64'(ld_fwd_data), 64'h55663344);
      check("t3_fwd_full", 64'(ld_fwd_full), 64'd1);
      ld_addr = 32'h204;
      #1;
      check("t4_miss_mask", 64'(ld_fwd_mask), 64'h0);
      check("t4_miss_data", 64'(ld_fwd_data), 64'h0);
      check("t4_miss_full", 64'(ld_fwd_full), 64'd0);
      step();
      st_valid  = 1'b1;
      st_addr   = 32'h204;
      st_data   = 32'h000000EE;
      st_strobe = 4'h1;
      #1;
      check("t4_same_cycle_invisible", 64'(ld_fwd_mask), 64'h0);
      st_valid  = 1'b0;
      enq(32'h204, 32'h000000EE, 4'h1);
      @(negedge clk);
      check("t4_part_mask", 64'(ld_fwd_mask), 64'h1);
      check("t4_part_data", 64'(ld_fwd_data), 64'hEE);
      check("t4_part_full", 64'(ld_fwd_full), 64'd0);
      step();
      async_reset("t4_rst");

      // Reset while the drain FSM waits for data_ok with three entries
      enq(32'h500, 32'hA5A5A5A5, 4'hF);
      enq(32'h504, 32'h5A5A5A5A, 4'hF);
      enq(32'h508, 32'h0F0F0F0F, 4'hF);
      ld_addr = 32'h504;
      dresp_addr_ok = 1'b1;
      step();
      dresp_addr_ok = 1'b0;
      @(negedge clk);
      check("t5_wait_dreq_valid", 64'(dreq_valid), 64'd0);
      check("t5_wait_count", 64'(count), 64'd3);
      check("t5_wait_fwd_mask", 64'(ld_fwd_mask), 64'hF);
      check("t5_wait_empty", 64'(empty), 64'd0);
      step();
      async_reset("t5_rst");

      // Two stores to one word with the drain stalled
      enq(32'h300, 32'h00001122, 4'h3);
      enq(32'h300, 32'h33440000, 4'hC);
      ld_addr = 32'h300;
      @(negedge clk);
`ifdef STORE_BUFFER_COALESCE_EN
      check("t6_count", 64'(count), 64'd1);
      check("t6_head_strobe", 64'(dreq_strobe), 64'hF);
`else
      check("t6_count", 64'(count), 64'd2);
      check("t6_head_strobe", 64'(dreq_strobe), 64'h3);
`endif
      check("t6_dreq_valid", 64'(dreq_valid), 64'd1);
      check("t6_fwd_mask", 64'(ld_fwd_mask), 64'hF);
      check("t6_fwd_data", 64'(ld_fwd_data), 64'h33441122);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Parametrised, multi-entry FIFO store buffer between the memory stage and the data bus.
- Retires stores in order to dbus through an addr_ok/data_ok handshake.
- Answers same-cycle load lookups with byte-granular forwarding, merged youngest-first across all buffered entries.
- Generalises the single-entry StorebufferEn/Addr/Data forwarding path used by writeback to DEPTH entries with byte strobes.

Parameters:
DEPTH, 4, number of entries; power of two, at least 2
ADDR_W, 32, address width
DATA_W, 32, data width; byte lanes NB = DATA_W/8

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
st_valid  in  1  store enqueue request
st_addr  in  ADDR_W  store byte address
st_data  in  DATA_W  store data, already lane-aligned
st_strobe  in  NB  byte enables
st_ready  out  1  enqueue accepted when st_valid && st_ready
ld_addr  in  ADDR_W  load lookup address (combinational)
ld_fwd_mask  out  NB  lanes supplied by the buffer
ld_fwd_data  out  DATA_W  forwarded lanes; lanes outside the mask are 0
ld_fwd_full  out  1  ld_fwd_mask is all ones
dreq_valid  out  1  drain request to dbus
dreq_addr  out  ADDR_W  head entry address
dreq_data  out  DATA_W  head entry data
dreq_strobe  out  NB  head entry strobe
dresp_addr_ok  in  1  dbus accepted the address
dresp_data_ok  in  1  dbus completed the write
empty  out  1  no valid entries and drain FSM idle; used for fence/exception
count  out  $clog2(DEPTH)+1  valid entry count

Behaviour:
- Reset: clk is the single clock. resetn low asynchronously clears:
  - valid bits, head, tail and count to 0; FSM to IDLE.
  - Outputs: st_ready=1, dreq_valid=0, empty=1, ld_fwd_mask=0, ld_fwd_data=0, ld_fwd_full=0.
  - Entry data/addr are not reset.
- Reset mid-drain: the in-flight entry is dropped with no retry. Bus-side recovery is the bus owner's problem.
- Storage: circular array; head = oldest, tail = next free. Pointers wrap modulo DEPTH.
- Enqueue:
  - st_ready = (count != DEPTH). No same-cycle bypass when full: a pop in the same cycle does not raise st_ready.
  - Accepted store is written at tail next edge; tail++, count++.
- Drain FSM:
  - IDLE: if count>0, assert dreq_valid with head fields and go to REQ.
  - REQ: dreq_valid=1; fields are stable until dresp_addr_ok.
    - addr_ok && data_ok in the same cycle: pop head, go to IDLE.
    - addr_ok only: go to WAIT.
  - WAIT: dreq_valid=0; on data_ok, pop head (head++, count--) and go to IDLE.
  - An entry is popped only after data_ok.
  - Back-to-back drains: IDLE costs one bubble cycle per entry.
- Simultaneous enqueue and pop: count unchanged; both pointers advance.
- Forwarding:
  - An entry matches when valid and addr[ADDR_W-1:2] == ld_addr[ADDR_W-1:2], byte offset ignored.
  - Entries in REQ/WAIT still participate until popped.
  - For each lane, the youngest matching entry with that strobe bit set supplies the byte.
  - Purely combinational, same cycle. A store enqueued this cycle is not visible.
- empty = (count==0) && FSM==IDLE.
- count width covers the value DEPTH.

Optional Feature:
- Macro: STORE_BUFFER_COALESCE_EN.
- Defined: an accepted store whose word address equals the youngest valid entry's is merged into that entry instead of allocating:
  - Lanes with st_strobe set are overwritten; strobe is ORed.
  - Condition: that entry is not the head while FSM is REQ or WAIT.
  - On merge: count and tail unchanged.
  - st_ready is 1 when full if the merge condition holds.
- Undefined: every accepted store allocates a new entry; no merge logic is present.

Test Plan:
- Reset, then enqueue addr 0x100 data 0xAABBCCDD strobe 0xF with addr_ok and data_ok tied high -> dreq_valid on cycle 2 with addr 0x100, popped the same cycle, empty=1 one cycle later.
- Fill 4 entries with addr_ok held low -> st_ready=0 and count=4. Fifth store is held off; release addr_ok, delay data_ok 3 cycles -> head popped only on data_ok and order preserved.
- Enqueue 0x200 data 0x11223344 strobe 0xF, then 0x202 data 0x55660000 strobe 0xC; lookup ld_addr 0x200 -> mask 0xF, data 0x55663344, fwd_full=1.
- Lookup ld_addr 0x204 with no match -> mask 0, data 0, fwd_full=0. Partial entry strobe 0x1 at 0x204 -> mask 0x1, fwd_full=0.
- Assert resetn low while FSM is in WAIT with 3 entries -> count=0, dreq_valid=0, empty=1 immediately, without waiting for a clock edge.
- With STORE_BUFFER_COALESCE_EN defined: two stores to 0x300 (strobe 0x3 then 0xC), drain stalled -> count=1 and strobe 0xF. With the macro undefined -> count=2.
